// File: rtl/pe_bus_arbiter.sv
// Registered round-robin arbiter for the shared intra-PU PE bus.
// Grants one PE per cycle, supports locked multi-beat bursts, one-hot destination valid.
module pe_bus_arbiter #(
  parameter int LOG_NUM_PE   = 3,
  parameter int NUM_PE_VALID = 5,
  parameter int DATA_LEN     = 16,
  localparam int NUM_PE      = 1 << LOG_NUM_PE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PE-1:0]            pe_req_v,
  input  logic [NUM_PE-1:0]            pe_req_last,
  input  logic [DATA_LEN*NUM_PE-1:0]   pe_req_data,
  input  logic [LOG_NUM_PE*NUM_PE-1:0] pe_req_dest,
  output logic [NUM_PE-1:0]            pe_req_rdy,
  input  logic                         bus_stall,
  output logic [DATA_LEN-1:0]          bus_data_out,
  output logic [NUM_PE-1:0]            bus_data_out_v,
  output logic [LOG_NUM_PE-1:0]        bus_src,
  output logic                         busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state_q, state_d;
  logic [LOG_NUM_PE-1:0]   owner_q, owner_d;
  logic [LOG_NUM_PE-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_PE-1:0]       valid_mask, eff_req;
  logic                    win_found;
  logic [LOG_NUM_PE-1:0]   win_idx, scan_idx, acc_idx;
  logic                    accept;
  logic [DATA_LEN-1:0]     data_arr [NUM_PE];
  logic [LOG_NUM_PE-1:0]   dest_arr [NUM_PE];

  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      valid_mask[i] = (i < NUM_PE_VALID);
      data_arr[i]   = pe_req_data[i*DATA_LEN +: DATA_LEN];
      dest_arr[i]   = pe_req_dest[i*LOG_NUM_PE +: LOG_NUM_PE];
    end
  end

  assign eff_req = pe_req_v & valid_mask;

  // Scan rr_ptr+1 .. rr_ptr+NUM_PE; the last step lands on rr_ptr itself.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_PE; k++) begin
      scan_idx = rr_ptr_q + LOG_NUM_PE'(k);
      if (!win_found && eff_req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    pe_req_rdy = '0;
    acc_idx    = win_idx;
    accept     = 1'b0;
    if (reset) begin
      unique case (state_q)
        IDLE: begin
          if (win_found && !bus_stall) begin
            pe_req_rdy[win_idx] = 1'b1;
            accept              = 1'b1;
            rr_ptr_d            = win_idx;
            if (!pe_req_last[win_idx]) begin
              state_d = BURST;
              owner_d = win_idx;
            end
          end
        end
        BURST: begin
          // Lock is held even when the owner drops valid, producing bubbles.
          acc_idx             = owner_q;
          pe_req_rdy[owner_q] = !bus_stall;
          accept              = !bus_stall && pe_req_v[owner_q];
          if (accept) begin
            rr_ptr_d = owner_q;
            if (pe_req_last[owner_q]) state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= LOG_NUM_PE'(NUM_PE - 1);
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_data_out   <= '0;
      bus_data_out_v <= '0;
      bus_src        <= '0;
    end else if (accept) begin
      bus_data_out   <= data_arr[acc_idx];
      bus_data_out_v <= NUM_PE'(1) << dest_arr[acc_idx];
      bus_src        <= acc_idx;
    end else begin
      bus_data_out_v <= '0;
    end
  end

  assign busy = (state_q == BURST) || (|bus_data_out_v);

endmodule

// File: tb/tb_pe_bus_arbiter.sv
// Directed-vector bench for pe_bus_arbiter with hand-computed expectations.
// Inputs change and outputs are sampled 2 time units after each rising edge.
module tb_pe_bus_arbiter;

  localparam int LOG_NUM_PE = 3;
  localparam int NUM_PE     = 8;
  localparam int DATA_LEN   = 16;

  logic                         clk;
  logic                         reset;
  logic [NUM_PE-1:0]            pe_req_v;
  logic [NUM_PE-1:0]            pe_req_last;
  logic [DATA_LEN*NUM_PE-1:0]   pe_req_data;
  logic [LOG_NUM_PE*NUM_PE-1:0] pe_req_dest;
  logic [NUM_PE-1:0]            pe_req_rdy;
  logic                         bus_stall;
  logic [DATA_LEN-1:0]          bus_data_out;
  logic [NUM_PE-1:0]            bus_data_out_v;
  logic [LOG_NUM_PE-1:0]        bus_src;
  logic                         busy;

  int vectors;
  int miscompares;

  pe_bus_arbiter #(
    .LOG_NUM_PE  (LOG_NUM_PE),
    .NUM_PE_VALID(5),
    .DATA_LEN    (DATA_LEN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pe_req_v      (pe_req_v),
    .pe_req_last   (pe_req_last),
    .pe_req_data   (pe_req_data),
    .pe_req_dest   (pe_req_dest),
    .pe_req_rdy    (pe_req_rdy),
    .bus_stall     (bus_stall),
    .bus_data_out  (bus_data_out),
    .bus_data_out_v(bus_data_out_v),
    .bus_src       (bus_src),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_pe(input int i, input logic v, input logic last,
                        input logic [DATA_LEN-1:0] data, input logic [LOG_NUM_PE-1:0] dest);
    pe_req_v[i]                               = v;
    pe_req_last[i]                            = last;
    pe_req_data[i*DATA_LEN +: DATA_LEN]       = data;
    pe_req_dest[i*LOG_NUM_PE +: LOG_NUM_PE]   = dest;
  endtask

  task automatic clear_all();
    pe_req_v    = '0;
    pe_req_last = '0;
    pe_req_data = '0;
    pe_req_dest = '0;
    bus_stall   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_all();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int order [6];
    vectors     = 0;
    miscompares = 0;
    order       = '{3, 0, 1, 3, 0, 1};

    // Reset: rdy held low even with a request present, outputs cleared.
    reset = 1'b0;
    clear_all();
    set_pe(0, 1'b1, 1'b1, 16'hFFFF, 3'd1);
    #1;
    check("rst_rdy", pe_req_rdy, 32'h0);
    tick();
    check("rst_data", bus_data_out, 32'h0);
    check("rst_v", bus_data_out_v, 32'h0);
    check("rst_src", bus_src, 32'h0);
    check("rst_busy", busy, 32'h0);
    clear_all();
    tick();
    reset = 1'b1;

    // Single beat: PE2 -> dest 5.
    set_pe(2, 1'b1, 1'b1, 16'h1234, 3'd5);
    #1;
    check("sb_rdy", pe_req_rdy, 32'h04);
    tick();
    check("sb_data", bus_data_out, 32'h1234);
    check("sb_v", bus_data_out_v, 32'h20);
    check("sb_src", bus_src, 32'h2);
    check("sb_busy", busy, 32'h1);
    clear_all();
    #1;
    check("sb_rdy_idle", pe_req_rdy, 32'h0);
    tick();
    check("sb_v_idle", bus_data_out_v, 32'h0);
    check("sb_data_hold", bus_data_out, 32'h1234);
    check("sb_busy_idle", busy, 32'h0);

    // Fairness: rr_ptr is now 2, so scan order gives 3,0,1,3,0,1 (wraps 7->0).
    set_pe(0, 1'b1, 1'b1, 16'hA000, 3'd7);
    set_pe(1, 1'b1, 1'b1, 16'hA001, 3'd6);
    set_pe(3, 1'b1, 1'b1, 16'hA003, 3'd4);
    #1;
    for (int j = 0; j < 6; j++) begin
      check("rr_rdy", pe_req_rdy, 32'h1 << order[j]);
      tick();
      check("rr_src", bus_src, 32'(order[j]));
      check("rr_v", bus_data_out_v, 32'h1 << (7 - order[j]));
      check("rr_data", bus_data_out, 32'hA000 + 32'(order[j]));
    end
    clear_all();
    tick();

    // Burst lock: PE1 3 beats with a bubble; PE4 waits.
    do_reset();
    set_pe(1, 1'b1, 1'b0, 16'hB001, 3'd6);
    set_pe(4, 1'b1, 1'b1, 16'hC004, 3'd0);
    #1;
    check("bl_rdy0", pe_req_rdy, 32'h02);
    tick();
    check("bl_src0", bus_src, 32'h1);
    check("bl_v0", bus_data_out_v, 32'h40);
    set_pe(1, 1'b0, 1'b0, 16'hB002, 3'd6);
    #1;
    check("bl_rdy_bubble", pe_req_rdy, 32'h02);
    tick();
    check("bl_v_bubble", bus_data_out_v, 32'h0);
    check("bl_busy_bubble", busy, 32'h1);
    set_pe(1, 1'b1, 1'b0, 16'hB002, 3'd6);
    #1;
    check("bl_rdy1", pe_req_rdy, 32'h02);
    tick();
    check("bl_data1", bus_data_out, 32'hB002);
    set_pe(1, 1'b1, 1'b1, 16'hB003, 3'd6);
    #1;
    check("bl_rdy_last", pe_req_rdy, 32'h02);
    tick();
    check("bl_data_last", bus_data_out, 32'hB003);
    check("bl_v_last", bus_data_out_v, 32'h40);
    set_pe(1, 1'b0, 1'b0, 16'h0, 3'd0);
    #1;
    check("bl_rdy_pe4", pe_req_rdy, 32'h10);
    tick();
    check("bl_src_pe4", bus_src, 32'h4);
    check("bl_v_pe4", bus_data_out_v, 32'h01);
    check("bl_data_pe4", bus_data_out, 32'hC004);
    clear_all();
    tick();
    check("bl_busy_end", busy, 32'h0);

    // Stall: PE3 and PE4 wait two cycles, then PE3 goes first from the reset pointer.
    do_reset();
    set_pe(3, 1'b1, 1'b1, 16'h3333, 3'd1);
    set_pe(4, 1'b1, 1'b1, 16'h4444, 3'd2);
    bus_stall = 1'b1;
    for (int j = 0; j < 2; j++) begin
      #1;
      check("st_rdy", pe_req_rdy, 32'h0);
      tick();
      check("st_v", bus_data_out_v, 32'h0);
    end
    bus_stall = 1'b0;
    #1;
    check("st_rdy_rel", pe_req_rdy, 32'h08);
    tick();
    check("st_src", bus_src, 32'h3);
    check("st_data", bus_data_out, 32'h3333);
    check("st_v_rel", bus_data_out_v, 32'h02);
    check("st_rdy_next", pe_req_rdy, 32'h10);
    set_pe(3, 1'b0, 1'b0, 16'h0, 3'd0);
    tick();
    check("st_src_pe4", bus_src, 32'h4);
    check("st_v_pe4", bus_data_out_v, 32'h04);
    // Sole requester equal to rr_ptr is still granted.
    #1;
    check("st_rdy_self", pe_req_rdy, 32'h10);
    tick();
    check("st_src_self", bus_src, 32'h4);
    clear_all();
    tick();

    // Masking: PE6 and PE7 are not populated.
    set_pe(6, 1'b1, 1'b1, 16'h6666, 3'd0);
    set_pe(7, 1'b1, 1'b0, 16'h7777, 3'd1);
    for (int j = 0; j < 10; j++) begin
      #1;
      check("mk_rdy", pe_req_rdy, 32'h0);
      tick();
      check("mk_v", bus_data_out_v, 32'h0);
      check("mk_busy", busy, 32'h0);
    end
    clear_all();

    // Reset mid-burst: rr_ptr is 4, PE2 is sole requester and enters BURST.
    set_pe(2, 1'b1, 1'b0, 16'hD002, 3'd3);
    #1;
    check("rb_rdy", pe_req_rdy, 32'h04);
    tick();
    check("rb_src", bus_src, 32'h2);
    check("rb_busy", busy, 32'h1);
    set_pe(2, 1'b1, 1'b0, 16'hD003, 3'd3);
    reset = 1'b0;
    #1;
    check("rb_rdy_rst", pe_req_rdy, 32'h0);
    tick();
    check("rb_data_rst", bus_data_out, 32'h0);
    check("rb_v_rst", bus_data_out_v, 32'h0);
    check("rb_src_rst", bus_src, 32'h0);
    check("rb_busy_rst", busy, 32'h0);
    reset = 1'b1;
    set_pe(0, 1'b1, 1'b1, 16'hE000, 3'd2);
    #1;
    check("rb_rdy_pe0", pe_req_rdy, 32'h01);
    tick();
    check("rb_src_pe0", bus_src, 32'h0);
    check("rb_data_pe0", bus_data_out, 32'hE000);
    check("rb_v_pe0", bus_data_out_v, 32'h04);
    clear_all();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
